// File: rtl/knight_rider_ctrl_if.sv
// Control/status bundle between the knight-rider sequencer and its host.
interface knight_rider_ctrl_if;
    logic       run;       // 1 = free-run, 0 = stopped / single-step
    logic       step_n;    // active-low pushbutton, asynchronous to the clock
    logic [1:0] speed;     // step period = (8 >> speed) base strobes
    logic       cnt_tick;  // counter step clock, one cycle per move
    logic       up;        // counter direction, 1 = toward SHIFT[0]
    logic [3:0] pos;       // index of lit LED, 0..9
    logic [1:0] state;     // debug: 0 STOP, 1 RUN, 2 DWELL

    modport master (output run, step_n, speed, input cnt_tick, up, pos, state);
    modport slave  (input run, step_n, speed, output cnt_tick, up, pos, state);
endinterface

// File: rtl/knight_rider_ctrl.sv
// Knight-rider sequencer: derives step strobes from the clock, runs the
// STOP/RUN/DWELL FSM and drives the shift counter's tick and direction
// through a two-cycle move pipeline so UP always settles before the tick.
module knight_rider_ctrl #(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned PS_W     = 16,
    parameter int unsigned DWELL    = 2
) (
    input  logic               clk_i,
    input  logic               clear_ni,
    knight_rider_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [3:0]      DW_LAST = 4'((DWELL > 0) ? DWELL - 1 : 0);
    localparam logic [3:0]      POS_MAX = 4'd9;

    state_e          state_q, state_d;
    logic [3:0]      dw_q, dw_d;
    logic [PS_W-1:0] ps_q;
    logic [2:0]      div_q;
    logic [3:0]      per_q;
    logic [2:0]      sync_q;
    logic            mv_q, tick_q, up_q;
    logic [3:0]      pos_q;

    logic            base_stb, div_run, step_stb, step_req, busy;
    logic            dir_next, land_end, move;
    logic [3:0]      pos_land;

    assign base_stb = (ps_q == PS_LAST);
    // Divider only advances while staying out of STOP; leaving RUN/DWELL clears it
    assign div_run  = (state_q != ST_STOP) && bus.run;
    assign step_stb = div_run && base_stb && (div_q == 3'(per_q - 4'd1));
    assign step_req = sync_q[2] & ~sync_q[1];
    assign busy     = mv_q | tick_q;
    assign dir_next = (pos_q == POS_MAX) ? 1'b1 : (pos_q == 4'd0) ? 1'b0 : up_q;
    assign pos_land = dir_next ? pos_q - 4'd1 : pos_q + 4'd1;
    assign land_end = (pos_land == 4'd0) || (pos_land == POS_MAX);

    // Base strobe prescaler, free-running
    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) ps_q <= '0;
        else           ps_q <= base_stb ? '0 : ps_q + PS_W'(1);
    end

    // Step divider; SPEED is captured only when the divider (re)loads
    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) begin
            div_q <= '0;
            per_q <= 4'd8;
        end else if (!div_run) begin
            div_q <= '0;
            per_q <= 4'd8 >> bus.speed;
        end else if (base_stb) begin
            if (div_q == 3'(per_q - 4'd1)) begin
                div_q <= '0;
                per_q <= 4'd8 >> bus.speed;
            end else begin
                div_q <= div_q + 3'd1;
            end
        end
    end

    // STEP key synchroniser plus previous-sample register for falling-edge detect
    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) sync_q <= '0;
        else           sync_q <= {sync_q[1:0], bus.step_n};
    end

    // FSM state and dwell counter registers
    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) begin
            state_q <= ST_STOP;
            dw_q    <= '0;
        end else begin
            state_q <= state_d;
            dw_q    <= dw_d;
        end
    end

    // FSM next state, dwell counting and move issue
    always_comb begin
        state_d = state_q;
        dw_d    = dw_q;
        move    = 1'b0;
        case (state_q)
            ST_STOP: begin
                if (bus.run) begin
                    state_d = ST_RUN;
                end else if (step_req && !busy) begin
                    move = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.run) begin
                    state_d = ST_STOP;
                end else if (step_stb) begin
                    move = 1'b1;
                    if ((DWELL > 0) && land_end) begin
                        state_d = ST_DWELL;
                        dw_d    = '0;
                    end
                end
            end
            ST_DWELL: begin
                if (!bus.run) begin
                    state_d = ST_STOP;
                    dw_d    = '0;
                end else if (step_stb) begin
                    if (dw_q == DW_LAST) state_d = ST_RUN;
                    else                 dw_d    = dw_q + 4'd1;
                end
            end
            default: state_d = ST_STOP;
        endcase
    end

    // Move pipeline: direction at issue, tick and position one cycle later
    always_ff @(posedge clk_i or negedge clear_ni) begin
        if (!clear_ni) begin
            mv_q   <= 1'b0;
            tick_q <= 1'b0;
            up_q   <= 1'b0;
            pos_q  <= '0;
        end else begin
            mv_q   <= move;
            tick_q <= mv_q;
            if (move) up_q  <= dir_next;
            if (mv_q) pos_q <= up_q ? pos_q - 4'd1 : pos_q + 4'd1;
        end
    end

    assign bus.cnt_tick = tick_q;
    assign bus.up       = up_q;
    assign bus.pos      = pos_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// Self-checking bench for knight_rider_ctrl: directed steps, randomized speed
// and STEP noise, checked against a position/timing model of the sweep rules.
module tb_knight_rider_ctrl;
    localparam int PRESCALE = 4;
    localparam int DWELL    = 2;
    localparam int BUDGET   = 2000;

    logic clk       = 1'b0;
    logic clear_n   = 1'b0;
    int   n_assert  = 0;
    int   n_fail    = 0;
    int   n_dwell   = 0;
    int   mpos      = 0;
    int   mup       = 0;
    logic last_up   = 1'b0;
    logic up_before = 1'b0;
    bit   rnd_step  = 1'b0;

    knight_rider_ctrl_if bus ();

    knight_rider_ctrl #(
        .PRESCALE (PRESCALE),
        .PS_W     (3),
        .DWELL    (DWELL)
    ) dut (
        .clk_i    (clk),
        .clear_ni (clear_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clock cycles between moves in free-run at a given speed
    function automatic int period(input int spd);
        return PRESCALE * (8 >> spd);
    endfunction

    // Reference rule: bounce at the ends, otherwise keep direction
    task automatic model_move();
        if (mpos == 9)      mup = 1;
        else if (mpos == 0) mup = 0;
        mpos = (mup == 1) ? mpos - 1 : mpos + 1;
    endtask

    task automatic one_cycle();
        @(negedge clk);
        up_before = last_up;
        last_up   = bus.up;
        if (bus.state == 2'd2) n_dwell++;
        if (rnd_step) bus.step_n = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_tick(output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 1; i <= BUDGET; i++) begin
            one_cycle();
            if (bus.cnt_tick === 1'b1) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset(input logic run_v, input logic [1:0] spd);
        clear_n    = 1'b0;
        bus.run    = run_v;
        bus.speed  = spd;
        bus.step_n = 1'b1;
        repeat (5) one_cycle();
        clear_n = 1'b1;
        mpos    = 0;
        mup     = 0;
    endtask

    // Follow nmoves free-run moves: position, direction, spacing, tick width, dwell time
    task automatic check_moves(input int nmoves, input int spd, input int first_gap);
        int gap;
        bit seen;
        bit land_prev;
        int n_land;
        land_prev = 1'b0;
        n_land    = 0;
        n_dwell   = 0;
        for (int k = 0; k < nmoves; k++) begin
            wait_tick(gap, seen);
            chk("tick_seen", 32'(seen), 1);
            if (!seen) return;
            model_move();
            chk("pos", 32'(bus.pos), mpos);
            chk("up", 32'(bus.up), mup);
            chk("up_setup", 32'(up_before), mup);
            if (k == 0 && first_gap != 0)
                chk("gap_first", gap + 1, first_gap);
            else if (k > 0)
                chk("gap", gap + 1, land_prev ? (DWELL + 1) * period(spd) : period(spd));
            land_prev = (mpos == 0 || mpos == 9);
            if (land_prev && k < nmoves - 1) n_land++;
            one_cycle();
            chk("tick_width", 32'(bus.cnt_tick), 0);
            chk("up_hold", 32'(bus.up), mup);
        end
        chk("dwell_cycles", n_dwell, n_land * DWELL * period(spd));
    endtask

    initial begin
        int  gap;
        bit  seen;
        int  spd;
        int  n_ticks;
        int  n_other;
        int  lo;
        int  hi;

        // Reset held with RUN=1
        clear_n    = 1'b0;
        bus.run    = 1'b1;
        bus.speed  = 2'd3;
        bus.step_n = 1'b1;
        repeat (5) one_cycle();
        chk("rst_tick", 32'(bus.cnt_tick), 0);
        chk("rst_up", 32'(bus.up), 0);
        chk("rst_pos", 32'(bus.pos), 0);
        chk("rst_state", 32'(bus.state), 0);

        // Full sweeps at fastest speed: two round trips plus a few moves
        clear_n = 1'b1;
        mpos    = 0;
        mup     = 0;
        check_moves(39, 3, 0);

        // Speed 0 spacing, then switch to speed 2 at the next reload
        do_reset(1'b1, 2'd0);
        check_moves(4, 0, 0);
        bus.speed = 2'd2;
        check_moves(3, 2, period(0));

        // Randomized speed with STEP noise during free-run
        for (int s = 0; s < 2; s++) begin
            spd = int'($urandom_range(0, 3));
            do_reset(1'b1, 2'(spd));
            rnd_step = 1'b1;
            check_moves(20, spd, 0);
            rnd_step   = 1'b0;
            bus.step_n = 1'b1;
        end

        // Single-step mode: 12 presses with random low/high lengths
        do_reset(1'b0, 2'($urandom_range(0, 3)));
        repeat (4) one_cycle();
        n_ticks = 0;
        n_other = 0;
        for (int p = 0; p < 12; p++) begin
            lo = int'($urandom_range(4, 20));
            hi = int'($urandom_range(4, 20));
            bus.step_n = 1'b0;
            for (int c = 0; c < lo + hi; c++) begin
                if (c == lo) bus.step_n = 1'b1;
                one_cycle();
                if (bus.state != 2'd0) n_other++;
                if (bus.cnt_tick === 1'b1) begin
                    n_ticks++;
                    model_move();
                    chk("step_pos", 32'(bus.pos), mpos);
                    chk("step_up", 32'(bus.up), mup);
                end
            end
        end
        repeat (10) one_cycle();
        chk("step_ticks", n_ticks, 12);
        chk("step_state", n_other, 0);
        chk("step_final_pos", 32'(bus.pos), 6);
        chk("step_final_up", 32'(bus.up), 1);

        // RUN dropped during dwell: stop at once, no further ticks, resume away from end
        do_reset(1'b1, 2'd3);
        check_moves(8, 3, 0);
        wait_tick(gap, seen);
        chk("dw_tick_seen", 32'(seen), 1);
        model_move();
        chk("dw_pos", 32'(bus.pos), mpos);
        chk("dw_state", 32'(bus.state), 2);
        one_cycle();
        bus.run = 1'b0;
        one_cycle();
        chk("dw_stop_state", 32'(bus.state), 0);
        n_ticks = 0;
        n_other = 0;
        repeat (60) begin
            one_cycle();
            if (bus.cnt_tick !== 1'b0) n_ticks++;
            if (bus.state != 2'd0) n_other++;
        end
        chk("dw_stop_ticks", n_ticks, 0);
        chk("dw_stop_stay", n_other, 0);
        chk("dw_stop_pos", 32'(bus.pos), 9);
        bus.run = 1'b1;
        wait_tick(gap, seen);
        chk("dw_resume_seen", 32'(seen), 1);
        model_move();
        chk("dw_resume_pos", 32'(bus.pos), mpos);
        chk("dw_resume_up", 32'(bus.up), mup);

        // Asynchronous clear while the tick to POS=5 is high
        do_reset(1'b1, 2'd3);
        check_moves(4, 3, 0);
        wait_tick(gap, seen);
        chk("ar_tick_seen", 32'(seen), 1);
        model_move();
        chk("ar_pre_pos", 32'(bus.pos), mpos);
        clear_n = 1'b0;
        #1;
        chk("ar_tick", 32'(bus.cnt_tick), 0);
        chk("ar_pos", 32'(bus.pos), 0);
        chk("ar_up", 32'(bus.up), 0);
        chk("ar_state", 32'(bus.state), 0);
        @(negedge clk);
        clear_n = 1'b1;
        mpos    = 0;
        mup     = 0;
        check_moves(3, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
